// File: rtl/dsp_rd_order_sched_pkg.sv
// Shared definitions for the read-order scheduler of the interconnect
// dispatcher: slave/length widths, queue depth and the layout of one
// order entry {slv_id, len}.
package dsp_rd_order_sched_pkg;

    localparam int SLV_AMT     = 2;
    localparam int SLV_ID_W    = (SLV_AMT > 1) ? $clog2(SLV_AMT) : 1;
    localparam int LEN_W       = 8;
    localparam int OST_DEPTH   = 4;
    localparam int OST_CNT_W   = $clog2(OST_DEPTH + 1);
    localparam int ORD_ENTRY_W = SLV_ID_W + LEN_W;

    // One outstanding read: which slave answers it and how many beats (len+1).
    typedef struct packed {
        logic [SLV_ID_W-1:0] slv_id;
        logic [LEN_W-1:0]    len;
    } ord_entry_t;

endpackage

// File: rtl/dsp_ord_queue.sv
// First-word-fall-through register queue holding outstanding read orders.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   push_i/data_i   write data_i at the tail (ignored when full)
//   pop_i           drop the head entry (ignored when empty)
//   head_o          current head entry, valid while empty_o=0
//   empty_o/full_o  occupancy flags
//   count_o         number of stored entries
module dsp_ord_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
        else if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/dsp_rd_order_sched.sv
// Read-order scheduler for one master port of the interconnect dispatcher.
// Records {slave, length} of every accepted AR, steers the R dispatcher to the
// slave whose beats are due next, counts forwarded beats and retires the head
// on its last beat so R data returns in AR issue order.
// Ports:
//   ACLK_i, ARESETn_i   clock, synchronous active-low reset
//   ar_hsk_i            AR accepted this cycle (ARVALID & ARREADY)
//   ar_slv_id_i/len_i   slave and ARLEN of that AR
//   r_valid_q1_i/ready  R skid-buffer input handshake
//   r_last_i            RLAST of the presented beat
//   r_slv_id_o          slave select for the R dispatcher
//   r_disable_o         no transaction due; R must not be forwarded
//   ar_stall_o          order queue full; AR dispatcher must hold ARREADY low
//   ost_cnt_o           outstanding transactions
//   len_err_o           sticky: RLAST disagreed with the beat count, or an AR
//                       was accepted while stalled
// Handshake semantics: a beat transfers only in a cycle where valid and ready
// are both high and r_disable_o is low; valid/ready are never combinationally
// derived from each other here, and ar_stall_o depends only on registered state.
module dsp_rd_order_sched
    import dsp_rd_order_sched_pkg::*;
(
    input  logic                 ACLK_i,
    input  logic                 ARESETn_i,
    input  logic                 ar_hsk_i,
    input  logic [SLV_ID_W-1:0]  ar_slv_id_i,
    input  logic [LEN_W-1:0]     ar_len_i,
    input  logic                 r_valid_q1_i,
    input  logic                 r_ready_q1_i,
    input  logic                 r_last_i,
    output logic [SLV_ID_W-1:0]  r_slv_id_o,
    output logic                 r_disable_o,
    output logic                 ar_stall_o,
    output logic [OST_CNT_W-1:0] ost_cnt_o,
    output logic                 len_err_o
);

    ord_entry_t           push_entry;
    ord_entry_t           head;
    logic                 q_empty, q_full;
    logic                 push, beat_fire, beat_last, pop;
    logic [LEN_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic                 len_err_q, len_err_d;

    assign push_entry = '{slv_id: ar_slv_id_i, len: ar_len_i};

    // A handshake while stalled is a protocol violation: drop it, flag it.
    assign push      = ar_hsk_i & ~q_full;
    assign beat_fire = r_valid_q1_i & r_ready_q1_i & ~q_empty;
    assign beat_last = (beat_cnt_q == head.len);
    // Retirement follows the counter, never RLAST.
    assign pop       = beat_fire & beat_last;

    dsp_ord_queue #(
        .DEPTH (OST_DEPTH),
        .W     (ORD_ENTRY_W)
    ) u_queue (
        .clk_i   (ACLK_i),
        .rst_ni  (ARESETn_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .empty_o (q_empty),
        .full_o  (q_full),
        .count_o (ost_cnt_o)
    );

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        len_err_d  = len_err_q;
        if (beat_fire) begin
            beat_cnt_d = beat_last ? '0 : beat_cnt_q + LEN_W'(1);
            if (r_last_i != beat_last) len_err_d = 1'b1;
        end
        if (ar_hsk_i && q_full) len_err_d = 1'b1;
    end

    always_ff @(posedge ACLK_i) begin
        if (!ARESETn_i) begin
            beat_cnt_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    assign r_slv_id_o  = q_empty ? '0 : head.slv_id;
    assign r_disable_o = q_empty;
    assign ar_stall_o  = q_full;
    assign len_err_o   = len_err_q;

endmodule
